hazard_detection_unit: RTL and testbench

Produces the pipeline-control detection information for the five-stage pipelined CPU: the one-hot source selects `en_B1`/`en_M2`/`en_H3` and the four 3-bit control codes. A downstream mux consumes these and reduces them to one 3-bit control word.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_detection_unit_if.sv | 38 +++
 rtl/mult_stall_counter.sv | 63 ++++++
 rtl/hazard_detection_unit.sv | 51 +++++
 tb/tb_hazard_detection_unit.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard detection unit:
// control-code bit positions, the code words and the multiply FSM states.
package hazard_pkg;

    localparam int BIT_FLUSH  = 2;
    localparam int BIT_HOLD   = 1;
    localparam int BIT_BUBBLE = 0;

    // Code word bit order is {flush_ifid, hold_front, bubble_idex}
    localparam logic [2:0] CODE_BRANCH =
        (3'b001 << BIT_FLUSH) | (3'b001 << BIT_BUBBLE);
    localparam logic [2:0] CODE_MULT   = (3'b001 << BIT_HOLD);
    localparam logic [2:0] CODE_HD     =
        (3'b001 << BIT_HOLD) | (3'b001 << BIT_BUBBLE);
    localparam logic [2:0] CODE_NONE   = 3'b000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mult_state_t;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side signal bundle of the hazard detection unit.
// slave is the detector's view, master the pipeline's.
interface hazard_detection_unit_if;

    logic       branch_taken;
    logic       idex_mult;
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       ifid_uses_rt;
    logic       en_B1;
    logic       en_M2;
    logic       en_H3;
    logic [2:0] en_Branch;
    logic [2:0] en_Mult;
    logic [2:0] en_HD;
    logic [2:0] nothing;
    logic       mult_busy;
    logic       mult_done;

    modport slave (
        input  branch_taken, idex_mult, idex_memread,
        input  idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
        output en_B1, en_M2, en_H3,
        output en_Branch, en_Mult, en_HD, nothing,
        output mult_busy, mult_done
    );

    modport master (
        output branch_taken, idex_mult, idex_memread,
        output idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
        input  en_B1, en_M2, en_H3,
        input  en_Branch, en_Mult, en_HD, nothing,
        input  mult_busy, mult_done
    );

endinterface

// File: rtl/mult_stall_counter.sv
// Multiply occupancy FSM: counts the BUSY cycles that follow the
// trigger cycle so EX is held for exactly MULT_LAT cycles per multiply.
module mult_stall_counter
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(MULT_LAT);

    mult_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Trigger cycle is not BUSY, so BUSY lasts MULT_LAT-1 cycles
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = BUSY;
                    cnt_n   = CW'(MULT_LAT - 2);
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Detects branch flush, multiply occupancy and load-use hazards and
// arbitrates them by fixed priority: branch > multiply > load-use.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_detection_unit_if.slave  hd
);

    logic busy;
    logic done;
    logic start;
    logic hit;
    logic m2_raw;

    assign start = hd.idex_mult && !hd.branch_taken;

    mult_stall_counter #(
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (hd.branch_taken),
        .busy  (busy),
        .done  (done)
    );

    assign hit = hd.idex_memread
              && (hd.idex_rt != 5'd0)
              && ((hd.idex_rt == hd.ifid_rs)
               || (hd.ifid_uses_rt && hd.idex_rt == hd.ifid_rt));

    // idex_mult only matters in IDLE; the held instruction is ignored when BUSY
    assign m2_raw = busy || hd.idex_mult;

    assign hd.en_B1     = !rst && hd.branch_taken;
    assign hd.en_M2     = !rst && !hd.branch_taken && m2_raw;
    assign hd.en_H3     = !rst && !hd.branch_taken && !m2_raw && hit;
    assign hd.mult_busy = !rst && busy;
    assign hd.mult_done = !rst && done;

    assign hd.en_Branch = CODE_BRANCH;
    assign hd.en_Mult   = CODE_MULT;
    assign hd.en_HD     = CODE_HD;
    assign hd.nothing   = CODE_NONE;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit with MULT_LAT = 32.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_hazard_detection_unit;

    localparam int LAT = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_detection_unit_if hif ();

    hazard_detection_unit #(
        .MULT_LAT (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hd  (hif)
    );

    task automatic idle_inputs();
        hif.branch_taken = 1'b0;
        hif.idex_mult    = 1'b0;
        hif.idex_memread = 1'b0;
        hif.idex_rt      = 5'd0;
        hif.ifid_rs      = 5'd0;
        hif.ifid_rt      = 5'd0;
        hif.ifid_uses_rt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        hif.branch_taken = 1'b1;
        hif.idex_mult    = 1'b1;
        hif.idex_memread = 1'b1;
        hif.idex_rt      = 5'd7;
        hif.ifid_rs      = 5'd7;
        #1;
        vectors++;
        if ({hif.en_B1, hif.en_M2, hif.en_H3, hif.mult_busy, hif.mult_done}
            !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 00000",
                     {hif.en_B1, hif.en_M2, hif.en_H3,
                      hif.mult_busy, hif.mult_done});
        end
        vectors++;
        if ({hif.en_Branch, hif.en_Mult, hif.en_HD, hif.nothing}
            !== 12'b101_010_011_000) begin
            miscompares++;
            $display("FAIL reset_codes got %b want 101010011000",
                     {hif.en_Branch, hif.en_Mult, hif.en_HD, hif.nothing});
        end
        do_reset();
    endtask

    task automatic test_load_use();
        // {memread, idex_rt, rs, rt, uses_rt, expected en_H3}
        logic [17:0] tbl [6];
        tbl[0] = {1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1};
        tbl[1] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0};
        tbl[2] = {1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b1};
        tbl[3] = {1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0};
        tbl[4] = {1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0};
        tbl[5] = {1'b1, 5'd31, 5'd30, 5'd29, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {hif.idex_memread, hif.idex_rt, hif.ifid_rs,
             hif.ifid_rt, hif.ifid_uses_rt} = tbl[i][17:1];
            #1;
            vectors++;
            if ({hif.en_B1, hif.en_M2, hif.en_H3} !== {2'b00, tbl[i][0]}) begin
                miscompares++;
                $display("FAIL load_use[%0d] sel got %b want %b", i,
                         {hif.en_B1, hif.en_M2, hif.en_H3}, {2'b00, tbl[i][0]});
            end
        end
        vectors++;
        if (hif.en_HD !== 3'b011) begin
            miscompares++;
            $display("FAIL en_HD got %b want 011", hif.en_HD);
        end
        idle_inputs();
    endtask

    task automatic test_mult_back_to_back();
        do_reset();
        hif.idex_mult = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            #1;
            vectors++;
            if ({hif.en_M2, hif.mult_busy, hif.mult_done} !==
                {1'b1, (c >= 2 && c <= LAT), (c == LAT)}) begin
                miscompares++;
                $display("FAIL mult cyc%0d m2/busy/done got %b want %b", c,
                         {hif.en_M2, hif.mult_busy, hif.mult_done},
                         {1'b1, (c >= 2 && c <= LAT), (c == LAT)});
            end
            @(negedge clk);
        end
        vectors++;
        if (hif.mult_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_busy got %b want 1", hif.mult_busy);
        end
        do_reset();
    endtask

    task automatic test_mult_hazard();
        do_reset();
        hif.idex_mult    = 1'b1;
        hif.idex_memread = 1'b1;
        hif.idex_rt      = 5'd12;
        hif.ifid_rs      = 5'd12;
        for (int c = 1; c <= LAT; c++) begin
            #1;
            vectors++;
            if ({hif.en_M2, hif.en_H3} !== 2'b10) begin
                miscompares++;
                $display("FAIL mult_hazard cyc%0d m2/h3 got %b want 10", c,
                         {hif.en_M2, hif.en_H3});
            end
            @(negedge clk);
        end
        hif.idex_mult = 1'b0;
        #1;
        vectors++;
        if ({hif.en_M2, hif.en_H3, hif.mult_busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL mult_hazard cyc33 m2/h3/busy got %b want 010",
                     {hif.en_M2, hif.en_H3, hif.mult_busy});
        end
        do_reset();
    endtask

    task automatic test_branch_abort();
        int dones = 0;
        do_reset();
        hif.idex_mult = 1'b1;
        for (int c = 1; c < 10; c++) @(negedge clk);
        hif.branch_taken = 1'b1;
        #1;
        vectors++;
        if ({hif.en_B1, hif.en_M2, hif.mult_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL abort_cyc10 b1/m2/done got %b want 100",
                     {hif.en_B1, hif.en_M2, hif.mult_done});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if ({hif.mult_busy, hif.en_M2} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_cyc11 busy/m2 got %b want 00",
                     {hif.mult_busy, hif.en_M2});
        end
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            #1;
            if (hif.mult_done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done got %0d pulses want 0", dones);
        end
        // A fresh multiply must get a full window after the abort
        @(negedge clk);
        hif.idex_mult = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            #1;
            vectors++;
            if ({hif.en_M2, hif.mult_done} !== {1'b1, (c == LAT)}) begin
                miscompares++;
                $display("FAIL post_abort cyc%0d m2/done got %b want %b", c,
                         {hif.en_M2, hif.mult_done}, {1'b1, (c == LAT)});
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_mult();
        do_reset();
        hif.idex_mult    = 1'b1;
        hif.idex_memread = 1'b1;
        hif.idex_rt      = 5'd3;
        hif.ifid_rs      = 5'd3;
        for (int c = 1; c < 5; c++) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if ({hif.en_B1, hif.en_M2, hif.en_H3, hif.mult_busy, hif.mult_done}
                !== 5'b0) begin
                miscompares++;
                $display("FAIL rst_mid[%0d] got %b want 00000", c,
                         {hif.en_B1, hif.en_M2, hif.en_H3,
                          hif.mult_busy, hif.mult_done});
            end
            @(negedge clk);
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        vectors++;
        if ({hif.mult_busy, hif.en_M2} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_release busy/m2 got %b want 00",
                     {hif.mult_busy, hif.en_M2});
        end
        @(negedge clk);
        hif.idex_mult = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            #1;
            vectors++;
            if ({hif.en_M2, hif.mult_busy, hif.mult_done} !==
                {1'b1, (c >= 2), (c == LAT)}) begin
                miscompares++;
                $display("FAIL post_rst cyc%0d m2/busy/done got %b want %b", c,
                         {hif.en_M2, hif.mult_busy, hif.mult_done},
                         {1'b1, (c >= 2), (c == LAT)});
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_priority();
        do_reset();
        hif.branch_taken = 1'b1;
        hif.idex_mult    = 1'b1;
        hif.idex_memread = 1'b1;
        hif.idex_rt      = 5'd8;
        hif.ifid_rs      = 5'd8;
        #1;
        vectors++;
        if ({hif.en_B1, hif.en_M2, hif.en_H3} !== 3'b100) begin
            miscompares++;
            $display("FAIL prio_all got %b want 100",
                     {hif.en_B1, hif.en_M2, hif.en_H3});
        end
        @(negedge clk);
        hif.branch_taken = 1'b0;
        hif.idex_mult    = 1'b0;
        #1;
        vectors++;
        if ({hif.mult_busy, hif.en_M2, hif.en_H3} !== 3'b001) begin
            miscompares++;
            $display("FAIL prio_after busy/m2/h3 got %b want 001",
                     {hif.mult_busy, hif.en_M2, hif.en_H3});
        end
        hif.idex_mult = 1'b1;
        #1;
        vectors++;
        if ({hif.en_B1, hif.en_M2, hif.en_H3} !== 3'b010) begin
            miscompares++;
            $display("FAIL prio_mult_over_hd got %b want 010",
                     {hif.en_B1, hif.en_M2, hif.en_H3});
        end
        do_reset();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_mult_back_to_back();
        test_mult_hazard();
        test_branch_abort();
        test_reset_mid_mult();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
